apb_master_arbiter: RTL and testbench

- Shares the single APB slave bus between two APB requesters:
  - Master 0: the I2C bridge interpreter.
  - Master 1: the on-chip housekeeping sequencer.
- Round-robin arbitration, with optional lock so an I2C burst keeps ownership across consecutive transfers.
- Runs a per-transfer pready timeout. On timeout it aborts the transfer and reports pslverr to the owning master.
- Sits between the masters' APB outputs and the register file / peripheral APB decoder.

---
 rtl/apb_arb_pkg.sv | 7 +
 rtl/apb_master_arbiter_if.sv | 11 +
 rtl/apb_rr_arbiter.sv | 15 +
 rtl/apb_master_arbiter.sv | 102 ++++++++++
 tb/tb_apb_master_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and constants for the two-master APB arbiter
package apb_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam int M_I2C = 0;
    localparam int M_HK = 1;
    localparam int WAIT_CNT_W = 16;
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: one APB request/response port plus the ownership lock hint
interface apb_master_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic psel, penable, pwrite, lock, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    modport master (output psel, penable, pwrite, paddr, pwdata, lock, input prdata, pready, pslverr);
    modport slave (input psel, penable, pwrite, paddr, pwdata, lock, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: combinational two-way round-robin pick with lock override
module apb_rr_arbiter import apb_arb_pkg::*; (
    input  logic [1:0] req,
    input  logic       lock_vld,
    input  logic       lock_idx,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    logic [1:0] elig;
    // a live lock masks out the other master; on a tie the one not granted last wins
    always_comb begin
        elig = lock_vld ? (req & (lock_idx ? 2'b10 : 2'b01)) : req;
        gnt = &elig ? ((last_grant == 1'(M_HK)) ? 2'b01 : 2'b10) : elig;
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB slave bus between the I2C bridge and the housekeeping sequencer
module apb_master_arbiter import apb_arb_pkg::*; #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    apb_master_arbiter_if.slave  m0,
    apb_master_arbiter_if.slave  m1,
    apb_master_arbiter_if.master s,
    output logic [1:0]           grant,
    output logic                 timeout_err
);
    state_t st, nxt;
    logic [1:0] req, arb_gnt;
    logic lock_vld, lock_idx, lock_hold, last_idx, owner;
    logic timeout, resp_edge, resp_err;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_sel;
    logic [DATA_BUS_WIDTH-1:0] wdata_sel, rdata_cap;

    assign req = {m1.psel & m1.penable, m0.psel & m0.penable};
    assign lock_hold = lock_vld & (lock_idx ? m1.lock : m0.lock);
    assign addr_sel = arb_gnt[1] ? m1.paddr : m0.paddr;
    assign wdata_sel = arb_gnt[1] ? m1.pwdata : m0.pwdata;
    assign timeout = st == ACCESS && !s.pready && wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
    assign resp_edge = st == ACCESS && (s.pready || timeout);
    assign rdata_cap = (s.pready && !s.pwrite) ? s.prdata : '0;
    assign resp_err = s.pready ? s.pslverr : 1'b1;
    assign s.lock = 1'b0;

    apb_rr_arbiter u_arb (
        .req(req),
        .lock_vld(lock_hold),
        .lock_idx(lock_idx),
        .last_grant(last_idx),
        .gnt(arb_gnt)
    );

    // transfer sequencing: grant, setup, wait for pready or timeout, one response cycle
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = |arb_gnt ? SETUP : IDLE;
            SETUP:   nxt = ACCESS;
            ACCESS:  nxt = resp_edge ? RESP : ACCESS;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state, ownership bookkeeping and every output are registered here
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            st <= IDLE;
            lock_vld <= 1'b0;
            lock_idx <= 1'b0;
            last_idx <= 1'(M_HK);
            owner <= 1'b0;
            wait_cnt <= '0;
            grant <= 2'b00;
            timeout_err <= 1'b0;
            s.psel <= 1'b0;
            s.penable <= 1'b0;
            s.pwrite <= 1'b0;
            s.paddr <= '0;
            s.pwdata <= '0;
            m0.pready <= 1'b0;
            m0.pslverr <= 1'b0;
            m0.prdata <= '0;
            m1.pready <= 1'b0;
            m1.pslverr <= 1'b0;
            m1.prdata <= '0;
        end else begin
            st <= nxt;
            wait_cnt <= (st == ACCESS && !s.pready) ? wait_cnt + 1'b1 : '0;
            timeout_err <= timeout;
            if (st == IDLE && |arb_gnt) begin
                owner <= arb_gnt[1];
                last_idx <= arb_gnt[1];
                grant <= arb_gnt;
                s.paddr <= addr_sel;
                s.pwdata <= wdata_sel;
                s.pwrite <= arb_gnt[1] ? m1.pwrite : m0.pwrite;
            end
            if (st == IDLE && !lock_hold) lock_vld <= 1'b0;
            if (st == RESP) begin
                lock_vld <= owner ? m1.lock : m0.lock;
                lock_idx <= owner;
            end
            s.psel <= nxt == SETUP || nxt == ACCESS;
            s.penable <= nxt == ACCESS;
            m0.pready <= resp_edge && !owner;
            m0.pslverr <= resp_edge && !owner && resp_err;
            m0.prdata <= (resp_edge && !owner) ? rdata_cap : '0;
            m1.pready <= resp_edge && owner;
            m1.pslverr <= resp_edge && owner && resp_err;
            m1.prdata <= (resp_edge && owner) ? rdata_cap : '0;
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed checks of arbitration, lock, timeout, slave error and reset
module tb_apb_master_arbiter;
    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic [1:0] grant;
    logic timeout_err;
    logic [1:0] r;
    int checks = 0;
    int errors = 0;

    apb_master_arbiter_if #(.AW(16), .DW(32)) m0_bus ();
    apb_master_arbiter_if #(.AW(16), .DW(32)) m1_bus ();
    apb_master_arbiter_if #(.AW(16), .DW(32)) s_bus ();

    apb_master_arbiter #(
        .ADDRESS_BUS_WIDTH(16),
        .DATA_BUS_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .m0(m0_bus),
        .m1(m1_bus),
        .s(s_bus),
        .grant(grant),
        .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_resp(output logic [1:0] seen);
        seen = 2'b00;
        for (int i = 0; i < 40 && seen == 2'b00; i++) begin
            tick();
            seen = {m1_bus.pready, m0_bus.pready};
        end
        check("resp_seen", 32'(seen != 2'b00), 1);
    endtask

    initial begin
        {m0_bus.psel, m0_bus.penable, m0_bus.pwrite, m0_bus.lock} = 4'b0;
        {m1_bus.psel, m1_bus.penable, m1_bus.pwrite, m1_bus.lock} = 4'b0;
        m0_bus.paddr = '0; m0_bus.pwdata = '0;
        m1_bus.paddr = '0; m1_bus.pwdata = '0;
        s_bus.pready = 1'b1; s_bus.pslverr = 1'b0; s_bus.prdata = 32'hDEADBEEF;
        tick(); tick();
        check("rst_psel", s_bus.psel, 0);
        check("rst_grant", grant, 0);
        check("rst_pready", {m1_bus.pready, m0_bus.pready}, 0);
        check("rst_prdata", m0_bus.prdata, 0);
        check("rst_timeout", timeout_err, 0);
        reset = 1'b0;

        m0_bus.paddr = 16'h0040; m0_bus.psel = 1; m0_bus.penable = 1;
        tick();
        check("rd_setup_sel", {s_bus.psel, s_bus.penable}, 2'b10);
        check("rd_setup_addr", s_bus.paddr, 32'h0040);
        check("rd_grant", grant, 2'b01);
        m0_bus.paddr = 16'h0999;
        tick();
        check("rd_access", {s_bus.psel, s_bus.penable}, 2'b11);
        check("rd_addr_hold", s_bus.paddr, 32'h0040);
        tick();
        check("rd_pready", {m1_bus.pready, m0_bus.pready}, 2'b01);
        check("rd_prdata", m0_bus.prdata, 32'hDEADBEEF);
        check("rd_pslverr", m0_bus.pslverr, 0);
        m0_bus.psel = 0; m0_bus.penable = 0;
        tick();
        check("rd_idle_pready", m0_bus.pready, 0);
        check("rd_idle_prdata", m0_bus.prdata, 0);
        check("rd_idle_psel", s_bus.psel, 0);

        reset = 1'b1; tick(); reset = 1'b0;
        m0_bus.psel = 1; m0_bus.penable = 1; m1_bus.psel = 1; m1_bus.penable = 1;
        wait_resp(r); check("rr_first", r, 2'b01); check("rr_grant0", grant, 2'b01);
        wait_resp(r); check("rr_second", r, 2'b10); check("rr_grant1", grant, 2'b10);
        wait_resp(r); check("rr_third", r, 2'b01);
        m0_bus.psel = 0; m0_bus.penable = 0; m1_bus.psel = 0; m1_bus.penable = 0;
        tick();

        reset = 1'b1; tick(); reset = 1'b0;
        m0_bus.pwrite = 1; m0_bus.lock = 1; m0_bus.psel = 1; m0_bus.penable = 1;
        m1_bus.pwrite = 0; m1_bus.psel = 1; m1_bus.penable = 1;
        for (int i = 0; i < 3; i++) begin
            wait_resp(r);
            check("lock_m0_owner", r, 2'b01);
        end
        m0_bus.psel = 0; m0_bus.penable = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_blocks_m1", {grant, 1'b0, s_bus.psel}, 4'b0100);
        end
        m0_bus.lock = 0;
        wait_resp(r);
        check("lock_release", r, 2'b10);
        check("lock_release_grant", grant, 2'b10);
        m1_bus.psel = 0; m1_bus.penable = 0;
        tick();

        s_bus.pready = 0;
        m1_bus.psel = 1; m1_bus.penable = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_access", {s_bus.psel, s_bus.penable, m1_bus.pready}, 3'b110);
        end
        tick();
        check("to_psel_drop", s_bus.psel, 0);
        check("to_pulse", timeout_err, 1);
        check("to_m1_resp", {m1_bus.pready, m1_bus.pslverr, m0_bus.pready}, 3'b110);
        check("to_prdata", m1_bus.prdata, 0);
        m1_bus.psel = 0; m1_bus.penable = 0; s_bus.pready = 1;
        tick();
        check("to_one_pulse", timeout_err, 0);

        m0_bus.pwrite = 1; m0_bus.pwdata = 32'hCAFE0001; s_bus.pslverr = 1;
        m0_bus.psel = 1; m0_bus.penable = 1;
        tick();
        check("err_wdata", s_bus.pwdata, 32'hCAFE0001);
        wait_resp(r);
        check("err_owner", r, 2'b01);
        check("err_pslverr", m0_bus.pslverr, 1);
        check("err_wr_prdata", m0_bus.prdata, 0);
        m0_bus.psel = 0; m0_bus.penable = 0; s_bus.pslverr = 0;
        tick();
        m0_bus.pwrite = 0; s_bus.prdata = 32'h12345678;
        m0_bus.psel = 1; m0_bus.penable = 1;
        wait_resp(r);
        check("after_err_owner", r, 2'b01);
        check("after_err_pslverr", m0_bus.pslverr, 0);
        check("after_err_prdata", m0_bus.prdata, 32'h12345678);
        m0_bus.psel = 0; m0_bus.penable = 0;
        tick();

        s_bus.pready = 0;
        m0_bus.psel = 1; m0_bus.penable = 1;
        tick(); tick(); tick();
        check("mid_wait", {s_bus.psel, s_bus.penable}, 2'b11);
        reset = 1'b1; m0_bus.psel = 0; m0_bus.penable = 0;
        tick();
        check("mid_rst_psel", {s_bus.psel, s_bus.penable}, 0);
        check("mid_rst_pready", {m1_bus.pready, m0_bus.pready}, 0);
        check("mid_rst_grant", grant, 0);
        reset = 1'b0; s_bus.pready = 1;
        m0_bus.psel = 1; m0_bus.penable = 1; m1_bus.psel = 1; m1_bus.penable = 1;
        wait_resp(r);
        check("mid_rst_tie", r, 2'b01);
        m0_bus.psel = 0; m0_bus.penable = 0; m1_bus.psel = 0; m1_bus.penable = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
